fifo_ctrl: RTL and testbench

- Pointer/flag controller that sits directly upstream of the 16x8 single-port RAM in the FIFO and drives its chip_sel, write_enable and address each cycle.
- Producer data goes straight to RAM data_in; consumer reads RAM data_out, qualified by rd_valid.
- Single RAM port allows one access per cycle, so the controller arbitrates simultaneous push/pop and tracks occupancy, full/empty and error flags.

---
 rtl/fifo_ctrl_pkg.sv | 16 +
 rtl/fifo_ctrl.sv | 125 ++++++++++++
 tb/tb_fifo_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO geometry used by the pointer/flag controller and the 16x8 RAM.
package fifo_ctrl_pkg;

    localparam int FIFO_ADDR_W = 4;
    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 2 ** FIFO_ADDR_W;
    localparam int FIFO_CNT_W  = FIFO_ADDR_W + 1;

    // Which side owns the single RAM port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PUSH = 2'd1,
        GNT_POP  = 2'd2
    } grant_e;

endpackage

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller in front of a single-port RAM.
// Arbitrates push/pop onto the one RAM port, tracks occupancy, and keeps
// sticky overflow/underflow flags. Popped data appears on RAM data_out
// one cycle after the grant, qualified by rd_valid.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    output logic              push_ok,
    output logic              pop_ok,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr
);

    localparam int             DEPTH    = 2 ** ADDR_W;
    localparam int             CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_last_pop;
    logic              r_rd_valid;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic              r_underflow;

    grant_e            w_grant;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic [CNT_W-1:0]  w_count_nxt;

    // Port arbitration: empty/full force the only useful grant, otherwise
    // alternate against whoever won last so neither side starves.
    always_comb begin
        w_grant = GNT_NONE;
        if (push && pop) begin
            if (r_empty)         w_grant = GNT_PUSH;
            else if (r_full)     w_grant = GNT_POP;
            else if (r_last_pop) w_grant = GNT_PUSH;
            else                 w_grant = GNT_POP;
        end else if (push && !r_full) begin
            w_grant = GNT_PUSH;
        end else if (pop && !r_empty) begin
            w_grant = GNT_POP;
        end
    end

    assign w_push_ok = (w_grant == GNT_PUSH);
    assign w_pop_ok  = (w_grant == GNT_POP);

    // RAM port drive; idle cycles park the address on the read pointer.
    always_comb begin
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = r_rd_ptr;
        if (w_push_ok) begin
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = r_wr_ptr;
        end else if (w_pop_ok) begin
            ram_cs   = 1'b1;
            ram_addr = r_rd_ptr;
        end
    end

    // Next occupancy; at most one of push/pop is granted so +/-1 suffices.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok)     w_count_nxt = r_count + CNT_W'(1);
        else if (w_pop_ok) w_count_nxt = r_count - CNT_W'(1);
    end

    // State update; reset overrides any grant made in the same cycle.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_pop  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
                r_last_pop <= 1'b0;
            end else if (w_pop_ok) begin
                r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                r_last_pop <= 1'b1;
            end
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == CNT_FULL);
            r_empty     <= (w_count_nxt == '0);
            r_rd_valid  <= w_pop_ok;
            r_overflow  <= r_overflow  | (push && !w_push_ok && r_full);
            r_underflow <= r_underflow | (pop  && !w_pop_ok  && r_empty);
        end
    end

    assign push_ok   = w_push_ok;
    assign pop_ok    = w_pop_ok;
    assign rd_valid  = r_rd_valid;
    assign full      = r_full;
    assign empty     = r_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural 16x8 single-port RAM
// attached so popped data can be checked end to end.
module tb_fifo_ctrl;

    logic       ck = 1'b0;
    logic       rst, push, pop;
    logic       push_ok, pop_ok, rd_valid, full, empty;
    logic [4:0] count;
    logic       overflow, underflow, ram_cs, ram_we;
    logic [3:0] ram_addr;

    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] mem [16];

    int n_vec = 0;
    int n_err = 0;

    always #5 ck = ~ck;

    fifo_ctrl #(.ADDR_W(4)) dut (
        .ck(ck), .rst(rst), .push(push), .pop(pop),
        .push_ok(push_ok), .pop_ok(pop_ok), .rd_valid(rd_valid),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr)
    );

    // Single-port RAM: write on cs&we, registered read on cs&!we.
    always @(posedge ck) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= din;
            else        dout <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; din = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_rdv", rd_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);

        // Pop on empty -> refused, underflow sticky, cleared by rst
        pop = 1'b1;
        #1;
        check("unf_pop_ok", pop_ok, 0);
        check("unf_cs", ram_cs, 0);
        tick();
        pop = 1'b0;
        check("unf_flag", underflow, 1);
        check("unf_count", count, 0);
        tick();
        check("unf_hold", underflow, 1);
        do_reset();
        check("unf_clr", underflow, 0);

        // Fill with 00..0F
        push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 8'(i);
            #1;
            check("fill_push_ok", push_ok, 1);
            check("fill_we", ram_we, 1);
            check("fill_addr", ram_addr, i);
            tick();
        end
        din = 8'hEE;
        #1;
        check("full_count", count, 16);
        check("full_flag", full, 1);
        check("full_empty", empty, 0);
        check("ovf_push_ok", push_ok, 0);
        check("ovf_cs", ram_cs, 0);
        tick();
        push = 1'b0;
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 16);

        // Drain 16 pops, data back in order
        pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("drain_pop_ok", pop_ok, 1);
            check("drain_we", ram_we, 0);
            check("drain_addr", ram_addr, i);
            tick();
            check("drain_rdv", rd_valid, 1);
            check("drain_data", dout, i);
        end
        pop = 1'b0;
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);
        check("drain_unf", underflow, 0);
        check("drain_ovf_hold", overflow, 1);
        tick();
        check("drain_rdv_off", rd_valid, 0);

        // Alternation under simultaneous push+pop
        do_reset();
        check("alt_ovf_clr", overflow, 0);
        push = 1'b1;
        din = 8'hCA; tick();
        din = 8'hCB; tick();
        pop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din = 8'hD0 + 8'(k);
            #1;
            check("alt_pop_ok", pop_ok, (k % 2 == 0) ? 1 : 0);
            check("alt_push_ok", push_ok, (k % 2 == 0) ? 0 : 1);
            tick();
            check("alt_rdv", rd_valid, (k % 2 == 0) ? 1 : 0);
            if (k == 0) check("alt_data0", dout, 8'hCA);
            if (k == 2) check("alt_data1", dout, 8'hCB);
        end
        push = 1'b0; pop = 1'b0;
        check("alt_count", count, 2);

        // Wrap: push 10, pop 10, push 10, then pop 10 in order
        do_reset();
        push = 1'b1;
        for (int i = 0; i < 10; i++) begin din = 8'h40 + 8'(i); tick(); end
        push = 1'b0; pop = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("wrap_rd_data", dout, 8'h49);
        pop = 1'b0; push = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 8'h80 + 8'(i);
            #1;
            check("wrap_waddr", ram_addr, (10 + i) % 16);
            tick();
        end
        push = 1'b0;
        check("wrap_count", count, 10);
        pop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("wrap_raddr", ram_addr, (10 + i) % 16);
            tick();
            check("wrap_data", dout, 8'h80 + i);
        end
        pop = 1'b0;
        check("wrap_empty", empty, 1);

        // Reset coincident with an accepted pop at count=5
        do_reset();
        push = 1'b1;
        for (int i = 0; i < 5; i++) begin din = 8'h10 + 8'(i); tick(); end
        push = 1'b0;
        check("mid_count5", count, 5);
        pop = 1'b1; rst = 1'b1;
        #1;
        check("mid_pop_ok", pop_ok, 1);
        tick();
        pop = 1'b0; rst = 1'b0;
        #1;
        check("mid_count", count, 0);
        check("mid_empty", empty, 1);
        check("mid_rdv", rd_valid, 0);
        check("mid_rptr", ram_addr, 0);
        push = 1'b1; din = 8'h77;
        #1;
        check("mid_wptr", ram_addr, 0);
        tick();
        push = 1'b0;
        check("mid_count1", count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
